noc_eject_if: RTL
=================

# noc_eject_if

Ejection-side network interface between a mesh router's local output port and its CPU's input port. Accepts 64-bit flits from the router, checks the destination coordinates against this node's coordinates, and buffers matching payloads in a small FIFO. Drains them to the CPU as 32-bit words over a valid/ready handshake. Misrouted flits are consumed and dropped so the router's local port never stalls on them.

## Interface
Parameters:
- DEPTH, 4, payload FIFO entries; power of two, minimum 2
- COORD_W, 16, width of each mesh coordinate
- DATA_W, 32, payload width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- my_x  in  COORD_W  this node's X coordinate (1-based), quasi-static
- my_y  in  COORD_W  this node's Y coordinate (1-based), quasi-static
- flit_in  in  2*COORD_W+DATA_W  flit from router: [63:48] dest_x, [47:32] dest_y, [31:0] payload
- flit_valid  in  1  flit_in holds a flit
- flit_ready  out  1  interface can consume a flit this cycle
- cpu_data  out  DATA_W  head-of-FIFO payload
- cpu_valid  out  1  cpu_data valid
- cpu_ready  in  1  CPU takes cpu_data this cycle
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- rx_cnt  out  16  accepted (matching) flit count (stats)
- drop_cnt  out  16  misrouted flit count (stats)

## Operation
- Flit transfer: flit_valid && flit_ready at a rising edge.
- Match: dest_x == my_x && dest_y == my_y. A matching transfer pushes the payload into the FIFO.
- Mismatch: the flit is consumed and discarded, and drop_cnt increments.
- flit_ready = !full || (cpu_valid && cpu_ready). A pop frees the slot in the same cycle.
- The ready rule is independent of whether the flit matches.
- CPU transfer: cpu_valid && cpu_ready. This pops the head entry.
- cpu_valid = (level != 0).
- cpu_data is the registered head entry and stays stable while cpu_valid && !cpu_ready.
- Push and pop in the same cycle: level is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- A flit that arrives when level == 0 is not bypassed to the CPU in the same cycle.
- rx_cnt and drop_cnt saturate at 16'hFFFF; they do not wrap.
- Reset (rst == 0 at a clock edge) takes priority over all traffic:
  - pointers, level and counters clear; FIFO contents are discarded.
  - cpu_valid = 0, cpu_data = 0, level = 0, rx_cnt = 0, drop_cnt = 0.
  - flit_ready = 0 while rst == 0.
- Reset mid-stream: an in-flight flit presented in the reset cycle is not consumed. The router must hold or re-present it.

## Timing
- Flit-to-CPU latency is 1 cycle: a flit accepted at edge N gives cpu_valid = 1 after edge N. This holds when the FIFO was empty.
- Back-to-back throughput is 1 flit per cycle in and 1 word per cycle out.
- flit_ready is combinational from the registered level and from cpu_ready. There is no combinational path from flit_in or flit_valid to any output.
- Counters and level update at the same edge as the transfer.

## Configuration
- NOC_EJECT_STATS_EN defined:
  - rx_cnt and drop_cnt are implemented as described.
- NOC_EJECT_STATS_EN undefined:
  - the counter registers are not built; rx_cnt and drop_cnt are driven constant 0.
  - Match/drop behaviour is identical, so misrouted flits are still consumed and discarded.

## Structure
- Shared package noc_pkg holds:
  - COORD_W, DATA_W and FLIT_W = 2*COORD_W+DATA_W
  - field offset constants DX_LSB = 48, DY_LSB = 32, PL_LSB = 0
  - typedef flit_t as a packed struct {dest_x, dest_y, payload}
- This package is shared with the injection interface and the router.
- One sub-module: noc_sync_fifo, a parameterised DEPTH x DATA_W synchronous FIFO with push/pop/full/empty/level.
- The top level does the destination compare, the handshake logic and the stats counters.

## Test plan
- Reset then single flit: my_x = 2, my_y = 2; flit 64'h0002_0002_DEADBEEF with cpu_ready = 1 -> cpu_valid high one cycle later, cpu_data = 32'hDEADBEEF, rx_cnt = 1, level returns to 0.
- Misroute: flit 64'h0003_0001_12345678 at node (2,2) -> flit_ready stays 1, cpu_valid stays 0, drop_cnt = 1, level = 0.
- Fill and backpressure: cpu_ready = 0 with 5 matching flits 1..5 and DEPTH = 4 -> level = 4 and flit_ready = 0 after the fourth flit; the fifth flit is held. Then cpu_ready = 1 -> output 1, 2, 3, 4, 5 in order with no loss.
- Simultaneous push/pop at full: level = 4, flit_valid = 1, cpu_ready = 1 -> the flit is accepted, level stays 4, and order is preserved across pointer wrap.
- Reset mid-stream: 3 entries queued, then rst = 0 for one cycle while flit_valid = 1 -> cpu_valid = 0, level = 0, counters = 0, the flit is not consumed, and flit_ready = 0 during reset.
- Saturation (stats build): 65 537 misrouted flits -> drop_cnt = 16'hFFFF and holds. Without NOC_EJECT_STATS_EN -> drop_cnt = 0 throughout.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions used by the injection and ejection interfaces and the router.
package noc_pkg;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FLIT_W  = 2*COORD_W + DATA_W;

  localparam int unsigned DX_LSB = 48;
  localparam int unsigned DY_LSB = 32;
  localparam int unsigned PL_LSB = 0;

  typedef struct packed {
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    logic [DATA_W-1:0]  payload;
  } flit_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// DEPTH x DATA_W synchronous FIFO; head entry is presented directly from storage.
module noc_sync_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     count;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // Gated so stale storage never shows after reset discards the contents.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_eject_if.sv
// NoC ejection interface: destination filter, payload FIFO, CPU handshake.
// Define NOC_EJECT_STATS_EN to build the saturating rx/drop counters.
module noc_eject_if #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned COORD_W = noc_pkg::COORD_W,
  parameter int unsigned DATA_W  = noc_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COORD_W-1:0]         my_x,
  input  logic [COORD_W-1:0]         my_y,
  input  logic [2*COORD_W+DATA_W-1:0] flit_in,
  input  logic                       flit_valid,
  output logic                       flit_ready,
  output logic [DATA_W-1:0]          cpu_data,
  output logic                       cpu_valid,
  input  logic                       cpu_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                rx_cnt,
  output logic [15:0]                drop_cnt
);

  logic [COORD_W-1:0] dest_x;
  logic [COORD_W-1:0] dest_y;
  logic [DATA_W-1:0]  payload;
  logic               match;
  logic               full;
  logic               empty;
  logic               pop;
  logic               fire;
  logic               push;

  assign dest_x  = flit_in[2*COORD_W+DATA_W-1 -: COORD_W];
  assign dest_y  = flit_in[COORD_W+DATA_W-1 -: COORD_W];
  assign payload = flit_in[DATA_W-1:0];
  assign match   = (dest_x == my_x) && (dest_y == my_y);

  assign cpu_valid  = !empty;
  assign pop        = cpu_valid && cpu_ready;
  // Readiness ignores the match result so misrouted flits drain at full rate.
  assign flit_ready = rst && (!full || pop);
  assign fire       = flit_valid && flit_ready;
  assign push       = fire && match;

  noc_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (payload),
    .pop       (pop),
    .pop_data  (cpu_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

`ifdef NOC_EJECT_STATS_EN
  logic drop;
  assign drop = fire && !match;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (push && rx_cnt != '1)   rx_cnt   <= rx_cnt + 16'd1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign rx_cnt   = '0;
  assign drop_cnt = '0;
`endif

endmodule
